// File: rtl/fifo_drain_if.sv
// Handshake bundle between the drain controller, the FIFO read port and the downstream stream.
// master = drain controller side, slave = FIFO/consumer side.
interface fifo_drain_if #(
   parameter int FIFO_WIDTH = 16
);
   logic [FIFO_WIDTH-1:0] fifo_data_out;
   logic                  fifo_empty;
   logic                  fifo_underflow;
   logic                  fifo_rd_en;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (
      input  fifo_data_out, fifo_empty, fifo_underflow, m_ready,
      output fifo_rd_en, m_data, m_valid
   );

   modport slave (
      output fifo_data_out, fifo_empty, fifo_underflow, m_ready,
      input  fifo_rd_en, m_data, m_valid
   );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side engine for a synchronous FIFO: absorbs the one-cycle read latency with a
// 2-entry skid buffer and re-presents the words as a valid/ready stream.
module fifo_drain_ctrl #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   fifo_drain_if.master         bus,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] words_out,
   output logic                 underflow_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  in_flight_q;
   logic [1:0]            entries_q, entries_d;
   logic [FIFO_WIDTH-1:0] buf_q [2];
   logic [FIFO_WIDTH-1:0] buf_d [2];
   logic [CNT_WIDTH-1:0]  words_out_q;
   logic                  underflow_err_q;

   logic                  pop;
   logic                  rd_en;
   logic [1:0]            occ_after_pop;

   // Control: next state and read request.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      rd_en         = 1'b0;
      pop           = (entries_q != 2'd0) && bus.m_ready;
      occ_after_pop = entries_q + {1'b0, in_flight_q} - {1'b0, pop};
      case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable) state_d = STOP;
            // Only read when the word is guaranteed a free buffer slot on arrival.
            rd_en = !bus.fifo_empty && (occ_after_pop < 2'd2);
         end
         STOP: begin
            if (enable)                                  state_d = RUN;
            else if (!in_flight_q && entries_q == 2'd0)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Skid buffer: slot 0 is the head; a pop shifts slot 1 down before the capture lands.
   always_comb begin
      buf_d     = buf_q;
      entries_d = entries_q;
      if (pop) begin
         buf_d[0]  = buf_q[1];
         entries_d = entries_q - 2'd1;
      end
      if (in_flight_q) begin
         if (entries_d == 2'd0) buf_d[0] = bus.fifo_data_out;
         else                   buf_d[1] = bus.fifo_data_out;
         entries_d = entries_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         in_flight_q     <= 1'b0;
         entries_q       <= 2'd0;
         words_out_q     <= '0;
         underflow_err_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         in_flight_q     <= rd_en;
         entries_q       <= entries_d;
         underflow_err_q <= underflow_err_q | bus.fifo_underflow;
         if (pop) words_out_q <= words_out_q + CNT_WIDTH'(1);
      end
   end

   // NOTE: buffer storage is left unreset on purpose; m_data is masked by entries_q,
   // so stale contents are never visible.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (entries_q != 2'd0);
   assign bus.m_data     = (entries_q != 2'd0) ? buf_q[0] : '0;
   assign busy           = (state_q != IDLE);
   assign words_out      = words_out_q;
   assign underflow_err  = underflow_err_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_flight_q && !pop && entries_q == 2'd2));

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: behavioural FIFO model, stream scoreboard,
// directed scenarios followed by a randomized soak.
module tb_fifo_drain_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable;
   logic        busy;
   logic [15:0] words_out;
   logic        underflow_err;

   fifo_drain_if #(.FIFO_WIDTH(16)) bus ();

   fifo_drain_ctrl #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .bus           (bus),
      .busy          (busy),
      .words_out     (words_out),
      .underflow_err (underflow_err)
   );

   always #5 clk = ~clk;

   // FIFO model: words written by the stimulus, read one edge after rd_en is accepted.
   logic [15:0] fifo_mem [4096];
   int          wr_idx = 0;
   int          rd_idx = 0;
   logic        flush  = 1'b0;
   // Every word the FIFO hands out must later appear on the stream, in order.
   logic [15:0] exp_mem [4096];
   int          exp_wr = 0;
   int          exp_rd = 0;

   assign bus.fifo_empty = (wr_idx == rd_idx);

   always @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_idx <= wr_idx;
      end else if (bus.fifo_rd_en && wr_idx != rd_idx) begin
         bus.fifo_data_out <= fifo_mem[rd_idx];
         exp_mem[exp_wr]   <= fifo_mem[rd_idx];
         exp_wr            <= exp_wr + 1;
         rd_idx            <= rd_idx + 1;
      end
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc, rd_cnt, pop_cnt, valid_cnt;
   int          first_rd, first_valid, first_pop, last_pop;
   int          outst = 0;
   int          total = 0;
   bit          held  = 1'b0;
   logic [15:0] held_data;
   logic [15:0] first_data, last_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      fifo_mem[wr_idx] = w;
      wr_idx++;
   endtask

   task automatic clr_stats();
      cyc = 0; rd_cnt = 0; pop_cnt = 0; valid_cnt = 0;
      first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
   endtask

   // Called with inputs already applied; checks the cycle just before the edge, then
   // advances one clock and returns 1 time unit after the edge.
   task automatic tick();
      logic pop_s;
      logic rd_s;
      #1;
      pop_s = bus.m_valid && bus.m_ready;
      rd_s  = bus.fifo_rd_en;
      chk("rd_en_while_empty", {31'd0, rd_s & bus.fifo_empty}, 32'd0);
      chk("outstanding_le_2", {31'd0, (outst + int'(rd_s) - int'(pop_s)) <= 2}, 32'd1);
      if (!bus.m_valid) chk("m_data_zero_when_invalid", {16'd0, bus.m_data}, 32'd0);
      if (held) begin
         chk("held_valid", {31'd0, bus.m_valid}, 32'd1);
         chk("held_data", {16'd0, bus.m_data}, {16'd0, held_data});
      end
      if (pop_s) begin
         chk("pop_has_expected_word", {31'd0, exp_rd != exp_wr}, 32'd1);
         if (exp_rd != exp_wr) begin
            chk("stream_order", {16'd0, bus.m_data}, {16'd0, exp_mem[exp_rd]});
            exp_rd++;
         end
         if (first_pop < 0) begin
            first_pop  = cyc;
            first_data = bus.m_data;
         end
         last_pop  = cyc;
         last_data = bus.m_data;
         pop_cnt++;
         total++;
      end
      if (rd_s) begin
         if (first_rd < 0) first_rd = cyc;
         rd_cnt++;
      end
      if (bus.m_valid) begin
         if (first_valid < 0) first_valid = cyc;
         valid_cnt++;
      end
      held      = bus.m_valid && !bus.m_ready;
      held_data = bus.m_data;
      outst     = outst + int'(rd_s) - int'(pop_s);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      enable = 1'b0;
      n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic mid_cycle_reset();
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("rst_m_data", {16'd0, bus.m_data}, 32'd0);
      chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_words_out", {16'd0, words_out}, 32'd0);
      chk("rst_underflow_err", {31'd0, underflow_err}, 32'd0);
      enable             = 1'b0;
      bus.m_ready        = 1'b0;
      bus.fifo_underflow = 1'b0;
      repeat (2) @(posedge clk);
      exp_rd = exp_wr;
      outst  = 0;
      held   = 1'b0;
      total  = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      enable             = 1'b0;
      bus.m_ready        = 1'b0;
      bus.fifo_underflow = 1'b0;

      // Reset state
      #2;
      chk("init_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("init_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
      chk("init_busy", {31'd0, busy}, 32'd0);
      chk("init_words_out", {16'd0, words_out}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming at full rate
      clr_stats();
      for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
      bus.m_ready = 1'b1;
      enable      = 1'b1;
      n = 0;
      while (pop_cnt < 5 && n < 30) begin tick(); n++; end
      chk("t2_delivered", pop_cnt, 5);
      chk("t2_latency", first_valid - first_rd, 2);
      chk("t2_back_to_back", last_pop - first_pop, 4);
      chk("t2_first_word", {16'd0, first_data}, 32'h0000A001);
      chk("t2_last_word", {16'd0, last_data}, 32'h0000A005);
      tick();
      tick();
      chk("t2_words_out", {16'd0, words_out}, 32'd5);
      chk("t2_rd_en_after_empty", {31'd0, bus.fifo_rd_en}, 32'd0);
      chk("t2_rd_count", rd_cnt, 5);
      wait_idle(20);

      // Backpressure
      clr_stats();
      for (int i = 0; i < 8; i++) push(16'hB000 + 16'(i));
      bus.m_ready = 1'b0;
      enable      = 1'b1;
      repeat (10) tick();
      chk("t3_rd_pulses", rd_cnt, 2);
      chk("t3_valid_held", {31'd0, bus.m_valid}, 32'd1);
      chk("t3_head_word", {16'd0, bus.m_data}, 32'h0000B000);
      bus.m_ready = 1'b1;
      n = 0;
      while (pop_cnt < 8 && n < 40) begin tick(); n++; end
      chk("t3_delivered", pop_cnt, 8);
      chk("t3_first_word", {16'd0, first_data}, 32'h0000B000);
      chk("t3_last_word", {16'd0, last_data}, 32'h0000B007);
      wait_idle(20);
      chk("t3_words_out", {16'd0, words_out}, 32'd13);

      // Empty FIFO
      clr_stats();
      bus.m_ready = 1'b1;
      enable      = 1'b1;
      repeat (20) tick();
      chk("t4_no_rd_en", rd_cnt, 0);
      chk("t4_no_valid", valid_cnt, 0);
      chk("t4_no_underflow_err", {31'd0, underflow_err}, 32'd0);
      wait_idle(20);

      // enable drops right after a read, with one word already buffered behind it
      clr_stats();
      for (int i = 0; i < 5; i++) push(16'hC000 + 16'(i));
      bus.m_ready = 1'b0;
      enable      = 1'b1;
      tick();
      tick();
      enable = 1'b0;
      tick();
      chk("t5_busy_in_stop", {31'd0, busy}, 32'd1);
      chk("t5_rd_before_drain", rd_cnt, 2);
      bus.m_ready = 1'b1;
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk("t5_idle", {31'd0, busy}, 32'd0);
      chk("t5_delivered", pop_cnt, 2);
      chk("t5_no_more_reads", rd_cnt, 2);
      chk("t5_fifo_left", wr_idx - rd_idx, 3);
      chk("t5_first_word", {16'd0, first_data}, 32'h0000C000);
      chk("t5_last_word", {16'd0, last_data}, 32'h0000C001);
      chk("t5_words_out", {16'd0, words_out}, 32'd15);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;

      // Sticky underflow, then a mid-operation reset
      bus.fifo_underflow = 1'b1;
      tick();
      bus.fifo_underflow = 1'b0;
      chk("t6_underflow_set", {31'd0, underflow_err}, 32'd1);
      repeat (5) tick();
      chk("t6_underflow_sticky", {31'd0, underflow_err}, 32'd1);
      for (int i = 0; i < 3; i++) push(16'hD000 + 16'(i));
      bus.m_ready = 1'b0;
      enable      = 1'b1;
      repeat (4) tick();
      chk("t6_valid_before_reset", {31'd0, bus.m_valid}, 32'd1);
      mid_cycle_reset();

      // Randomized soak
      clr_stats();
      enable = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 99) < 45 && (wr_idx - rd_idx) < 32) push(16'($urandom));
         bus.m_ready = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 99) < 4) enable = ~enable;
         tick();
      end
      enable      = 1'b1;
      bus.m_ready = 1'b1;
      n = 0;
      while ((wr_idx != rd_idx || outst != 0) && n < 200) begin tick(); n++; end
      chk("rand_drained", {31'd0, wr_idx == rd_idx && outst == 0}, 32'd1);
      wait_idle(20);
      chk("rand_scoreboard_empty", {31'd0, exp_rd == exp_wr}, 32'd1);
      chk("rand_words_out", {16'd0, words_out}, {16'd0, 16'(total)});
      chk("rand_underflow_err", {31'd0, underflow_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

endmodule
